bus_req_client: RTL and testbench

BUS_REQ_CLIENT -- requirements
Module: bus_req_client

---
 rtl/bus_req_client_if.sv | 25 ++
 rtl/bus_req_client.sv | 121 ++++++++++++
 tb/tb_bus_req_client.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_req_client_if.sv
// rtl/bus_req_client_if.sv - job/arbiter signal bundle for bus_req_client
interface bus_req_client_if;
    logic       start;
    logic       chan;
    logic [3:0] len;
    logic       gnt0;
    logic       gnt1;
    logic       req0;
    logic       req1;
    logic       busy;
    logic       own;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    modport master (
        input  start, chan, len, gnt0, gnt1,
        output req0, req1, busy, own, done, err, err_code
    );

    modport slave (
        output start, chan, len, gnt0, gnt1,
        input  req0, req1, busy, own, done, err, err_code
    );
endinterface

// File: rtl/bus_req_client.sv
// rtl/bus_req_client.sv - requests one arbiter port, holds ownership for len cycles, releases
module bus_req_client #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    bus_req_client_if.master   bus
);

    typedef enum logic [1:0] {IDLE, REQ, OWN, REL} state_t;

    state_t     state, state_n;
    logic       chan_q, chan_n;
    logic [3:0] len_q, len_n;
    logic [3:0] hold_q, hold_n;
    logic [7:0] wait_q, wait_n;
    logic       req0_q, req1_q, busy_q, own_q, done_q, err_q;
    logic       req0_n, req1_n, busy_n, own_n, done_n, err_n;
    logic [1:0] code_q, code_n;
    logic       gnt_sel;
    logic       req_on;

    // The unselected grant line never influences the job.
    assign gnt_sel = chan_q ? bus.gnt1 : bus.gnt0;

    always_comb begin
        state_n = state;
        chan_n  = chan_q;
        len_n   = len_q;
        hold_n  = hold_q;
        wait_n  = wait_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        code_n  = code_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    chan_n  = bus.chan;
                    len_n   = (bus.len == 4'd0) ? 4'd1 : bus.len;
                    wait_n  = 8'd0;
                    state_n = REQ;
                end
            end
            REQ: begin
                wait_n = wait_q + 8'd1;
                // Grant is tested first so it wins over a simultaneous timeout.
                if (gnt_sel) begin
                    hold_n  = len_q;
                    state_n = OWN;
                end else if (wait_q + 8'd1 == 8'(TIMEOUT)) begin
                    err_n   = 1'b1;
                    code_n  = 2'b01;
                    state_n = IDLE;
                end
            end
            OWN: begin
                hold_n = hold_q - 4'd1;
                if (hold_q == 4'd1) begin
                    state_n = REL;
                end else if (!gnt_sel) begin
                    err_n   = 1'b1;
                    code_n  = 2'b10;
                    state_n = IDLE;
                end
            end
            REL: begin
                if (!gnt_sel) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are decoded from the next state so they register with it.
        req_on = (state_n == REQ) || (state_n == OWN);
        req0_n = req_on && !chan_n;
        req1_n = req_on && chan_n;
        busy_n = (state_n != IDLE);
        own_n  = (state_n == OWN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            chan_q <= 1'b0;
            len_q  <= 4'd0;
            hold_q <= 4'd0;
            wait_q <= 8'd0;
            req0_q <= 1'b0;
            req1_q <= 1'b0;
            busy_q <= 1'b0;
            own_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            code_q <= 2'b00;
        end else begin
            state  <= state_n;
            chan_q <= chan_n;
            len_q  <= len_n;
            hold_q <= hold_n;
            wait_q <= wait_n;
            req0_q <= req0_n;
            req1_q <= req1_n;
            busy_q <= busy_n;
            own_q  <= own_n;
            done_q <= done_n;
            err_q  <= err_n;
            code_q <= code_n;
        end
    end

    assign bus.req0     = req0_q;
    assign bus.req1     = req1_q;
    assign bus.busy     = busy_q;
    assign bus.own      = own_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.err_code = code_q;

endmodule

// File: tb/tb_bus_req_client.sv
// tb/tb_bus_req_client.sv - directed and random checks of bus_req_client against a job-level model
module tb_bus_req_client;

    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bus_req_client_if bif ();

    bus_req_client #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int tests = 0;
    int fails = 0;

    logic       e_req0, e_req1, e_busy, e_own, e_done, e_err;
    logic [1:0] e_code;

    int   c_req0, c_req1, c_own, c_done, c_err, c_rise;
    logic prev_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- job-level reference model ----------------
    function automatic void mclear();
        e_req0 = 1'b0; e_req1 = 1'b0; e_busy = 1'b0; e_own = 1'b0;
        e_done = 1'b0; e_err  = 1'b0; e_code = 2'b00;
    endfunction

    function automatic logic gsel(input logic ch);
        return ch ? bif.gnt1 : bif.gnt0;
    endfunction

    task automatic mstep(output bit ab);
        @(posedge clk or negedge rst);
        ab = !rst;
        if (ab) mclear();
    endtask

    function automatic void mabort(input logic [1:0] code);
        e_req0 = 1'b0; e_req1 = 1'b0; e_own = 1'b0; e_busy = 1'b0;
        e_err  = 1'b1; e_code = code;
    endfunction

    task automatic mjob(input logic ch, input logic [3:0] ln);
        int  hold;
        int  w;
        int  o;
        bit  ab;
        bit  fin;
        hold = (ln == 4'd0) ? 1 : int'(ln);
        e_busy = 1'b1; e_req0 = !ch; e_req1 = ch; e_own = 1'b0;
        w = 0; fin = 1'b0;
        while (!fin) begin
            mstep(ab);
            if (ab) return;
            w++;
            if (gsel(ch)) fin = 1'b1;
            else if (w == TO) begin mabort(2'b01); return; end
        end
        e_own = 1'b1;
        o = 0; fin = 1'b0;
        while (!fin) begin
            mstep(ab);
            if (ab) return;
            o++;
            if (o == hold) fin = 1'b1;
            else if (!gsel(ch)) begin mabort(2'b10); return; end
        end
        e_req0 = 1'b0; e_req1 = 1'b0; e_own = 1'b0;
        fin = 1'b0;
        while (!fin) begin
            mstep(ab);
            if (ab) return;
            if (!gsel(ch)) fin = 1'b1;
        end
        e_busy = 1'b0; e_done = 1'b1;
    endtask

    initial begin
        mclear();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) mclear();
            else begin
                e_done = 1'b0; e_err = 1'b0;
                if (bif.start) mjob(bif.chan, bif.len);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("cycle", 32'({bif.req0, bif.req1, bif.busy, bif.own, bif.done, bif.err, bif.err_code}),
                32'({e_req0, e_req1, e_busy, e_own, e_done, e_err, e_code}));
            chk("req_mutex", 32'(bif.req0 & bif.req1), 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
        c_req0 += int'(bif.req0);
        c_req1 += int'(bif.req1);
        c_own  += int'(bif.own);
        c_done += int'(bif.done);
        c_err  += int'(bif.err);
        if (bif.busy && !prev_busy) c_rise++;
        prev_busy = bif.busy;
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        c_req0 = 0; c_req1 = 0; c_own = 0; c_done = 0; c_err = 0; c_rise = 0;
    endtask

    task automatic idle_inputs();
        bif.start = 1'b0; bif.chan = 1'b0; bif.len = 4'd0; bif.gnt0 = 1'b0; bif.gnt1 = 1'b0;
    endtask

    initial begin
        idle_inputs();
        clr();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_state", 32'({bif.req0, bif.req1, bif.busy, bif.own, bif.done, bif.err, bif.err_code}), 32'd0);

        // chan0 len3, grant after 2 wait cycles; start on first edge after reset release
        rst = 1'b1;
        bif.start = 1'b1; bif.chan = 1'b0; bif.len = 4'd3;
        cyc(); bif.start = 1'b0;
        cyc(); bif.gnt0 = 1'b1;
        repeat (4) cyc();
        bif.gnt0 = 1'b0;
        repeat (3) cyc();
        chk("t1_req0_cycles", 32'(c_req0), 32'd5);
        chk("t1_own_cycles", 32'(c_own), 32'd3);
        chk("t1_done", 32'(c_done), 32'd1);
        chk("t1_req1", 32'(c_req1), 32'd0);

        // chan1 timeout
        clr(); idle_inputs();
        bif.start = 1'b1; bif.chan = 1'b1; bif.len = 4'd5;
        cyc(); bif.start = 1'b0;
        repeat (20) cyc();
        chk("t2_req1_cycles", 32'(c_req1), 32'd15);
        chk("t2_err", 32'(c_err), 32'd1);
        chk("t2_code_busy", 32'({bif.err_code, bif.busy}), 32'b010);

        // grant lost in third OWN cycle
        clr(); idle_inputs();
        bif.start = 1'b1; bif.chan = 1'b0; bif.len = 4'd8; bif.gnt0 = 1'b1;
        cyc(); bif.start = 1'b0;
        repeat (3) cyc();
        bif.gnt0 = 1'b0;
        cyc();
        chk("t3_err_now", 32'({bif.err, bif.err_code, bif.req0, bif.own}), 32'b11000);
        repeat (2) cyc();
        chk("t3_own_cycles", 32'(c_own), 32'd3);
        chk("t3_err_count", 32'(c_err), 32'd1);

        // len=0 gives one OWN cycle; gnt1 on a chan0 job is ignored
        clr(); idle_inputs();
        bif.start = 1'b1; bif.chan = 1'b0; bif.len = 4'd0; bif.gnt0 = 1'b1; bif.gnt1 = 1'b1;
        cyc(); bif.start = 1'b0;
        cyc();
        cyc(); bif.gnt0 = 1'b0;
        repeat (3) cyc();
        chk("t4_own_cycles", 32'(c_own), 32'd1);
        chk("t4_req1", 32'(c_req1), 32'd0);
        chk("t4_done", 32'(c_done), 32'd1);

        // start held while busy, then reset during OWN
        clr(); idle_inputs();
        bif.start = 1'b1; bif.chan = 1'b1; bif.len = 4'd10; bif.gnt1 = 1'b1;
        repeat (3) cyc();
        chk("t5_single_job", 32'(c_rise), 32'd1);
        chk("t5_own_before_rst", 32'(bif.own), 32'd1);
        bif.start = 1'b0;
        rst = 1'b0;
        #1;
        chk("t5_rst_async", 32'({bif.req0, bif.req1, bif.busy, bif.own, bif.done, bif.err, bif.err_code}), 32'd0);
        clr();
        repeat (2) cyc();
        rst = 1'b1; bif.gnt1 = 1'b0;
        repeat (2) cyc();
        chk("t5_no_pulse", 32'(c_done + c_err), 32'd0);

        // grant coincides with the timeout edge
        clr(); idle_inputs();
        bif.start = 1'b1; bif.chan = 1'b0; bif.len = 4'd2;
        cyc(); bif.start = 1'b0;
        repeat (14) cyc();
        bif.gnt0 = 1'b1;
        repeat (3) cyc();
        bif.gnt0 = 1'b0;
        repeat (2) cyc();
        chk("t6_err", 32'(c_err), 32'd0);
        chk("t6_own_cycles", 32'(c_own), 32'd2);
        chk("t6_req0_cycles", 32'(c_req0), 32'd17);
        chk("t6_done", 32'(c_done), 32'd1);

        // random traffic with occasional resets
        idle_inputs();
        for (int i = 0; i < 4000; i++) begin
            bif.start = ($urandom_range(3) == 0);
            bif.chan  = 1'($urandom_range(1));
            bif.len   = 4'($urandom_range(15));
            if ($urandom_range(5) == 0) bif.gnt0 = ~bif.gnt0;
            if ($urandom_range(5) == 0) bif.gnt1 = ~bif.gnt1;
            if ($urandom_range(600) == 0) rst = 1'b0;
            else if (!rst && $urandom_range(1) == 0) rst = 1'b1;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
